// File: rtl/hilo_if.sv
// Bus between the HI/LO controller, the pipeline and the divider/multiplier.
// slave = controller side, master = pipeline/unit side.
interface hilo_if;
    logic        start;
    logic        op;
    logic        abort;
    logic        div_control;
    logic        mult_control;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        div_zero;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        exc_div0;

    modport slave (
        input  start, op, abort, div_hi, div_lo, div_zero, mult_hi, mult_lo,
        output div_control, mult_control, busy, done, hi_out, lo_out, exc_div0
    );

    modport master (
        output start, op, abort, div_hi, div_lo, div_zero, mult_hi, mult_lo,
        input  div_control, mult_control, busy, done, hi_out, lo_out, exc_div0
    );
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO sequencer for a multi-cycle divider and multiplier: IDLE->ISSUE->WAIT->COMMIT.
// Optional macro DIV0_TRAP_EN: divide-by-zero raises exc_div0 and leaves HI/LO untouched.
module hilo_ctrl #(
    parameter int DIV_LAT  = 32,
    parameter int MULT_LAT = 1
) (
    input logic   clk,
    input logic   reset,
    hilo_if.slave bus
);
    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;

    state_t        state, state_nxt;
    logic          op_q;
    logic [CW-1:0] cnt;
    logic [31:0]   hi_q, lo_q;
    logic          exc_q;
    logic          wait_done, commit_edge, trap;

    assign wait_done   = (cnt == CW'(1));
    assign commit_edge = (state == WAIT) && wait_done && !bus.abort;

`ifdef DIV0_TRAP_EN
    logic div0_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                div0_q <= 1'b0;
        else if (state == ISSUE)   div0_q <= 1'b0;
        else if (state == WAIT)    div0_q <= div0_q | bus.div_zero;
    end

    // include the final WAIT cycle's flag, which is sampled on the commit edge itself
    assign trap = !op_q && (div0_q || bus.div_zero);
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start && !bus.abort) state_nxt = ISSUE;
            ISSUE:   state_nxt = bus.abort ? IDLE : WAIT;
            WAIT: begin
                if (bus.abort)     state_nxt = IDLE;
                else if (wait_done) state_nxt = COMMIT;
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q  <= 1'b0;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            exc_q <= 1'b0;
        end else begin
            exc_q <= commit_edge && trap;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.start && !bus.abort) op_q <= bus.op;
                end
                ISSUE:   cnt <= op_q ? CW'(MULT_LAT) : CW'(DIV_LAT);
                WAIT:    cnt <= cnt - CW'(1);
                default: cnt <= '0;
            endcase
            if (commit_edge && !trap) begin
                hi_q <= op_q ? bus.mult_hi : bus.div_hi;
                lo_q <= op_q ? bus.mult_lo : bus.div_lo;
            end
        end
    end

    always_comb begin
        bus.busy         = (state == ISSUE) || (state == WAIT);
        bus.done         = (state == COMMIT);
        bus.div_control  = (state == ISSUE) && !op_q;
        bus.mult_control = (state == ISSUE) && op_q;
        bus.hi_out       = hi_q;
        bus.lo_out       = lo_q;
        bus.exc_div0     = exc_q;
    end
endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed + randomized bench for hilo_ctrl with behavioural divider/multiplier models.
module tb_hilo_ctrl;
    localparam int DIV_LAT  = 32;
    localparam int MULT_LAT = 1;
`ifdef DIV0_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hilo_if bus ();
    hilo_ctrl #(.DIV_LAT(DIV_LAT), .MULT_LAT(MULT_LAT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ua, ub, umh, uml;
    logic [31:0] eh, el;
    int          dcnt = 0, mcnt = 0;

    function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 32'd0) return 64'd0;
        sa = int'(a);
        sb = int'(b);
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    // Units: garbage until LAT cycles after the start pulse is seen, then the result.
    always @(negedge clk) begin
        if (bus.div_control) begin
            dcnt <= DIV_LAT;
            bus.div_hi <= $urandom;
            bus.div_lo <= $urandom;
        end else if (dcnt > 1) begin
            dcnt <= dcnt - 1;
            bus.div_hi <= $urandom;
            bus.div_lo <= $urandom;
        end else begin
            dcnt <= 0;
            {bus.div_hi, bus.div_lo} <= div_ref(ua, ub);
        end
        bus.div_zero <= (ub == 32'd0);
        if (bus.mult_control) begin
            mcnt <= MULT_LAT;
            bus.mult_hi <= $urandom;
            bus.mult_lo <= $urandom;
        end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
            bus.mult_hi <= $urandom;
            bus.mult_lo <= $urandom;
        end else begin
            mcnt <= 0;
            bus.mult_hi <= umh;
            bus.mult_lo <= uml;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cycle(input string tag, input bit b, input bit d, input bit dc,
                             input bit mc, input bit ex);
        chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
        chk({tag, ".done"}, 32'(bus.done), 32'(d));
        chk({tag, ".div_control"}, 32'(bus.div_control), 32'(dc));
        chk({tag, ".mult_control"}, 32'(bus.mult_control), 32'(mc));
        chk({tag, ".exc_div0"}, 32'(bus.exc_div0), 32'(ex));
        chk({tag, ".hi"}, bus.hi_out, eh);
        chk({tag, ".lo"}, bus.lo_out, el);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle; start is raised in this cycle (cycle 0). Returns in an IDLE cycle.
    task automatic run_op(input string tag, input bit o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] mh, input logic [31:0] ml, input int abort_cyc,
                          input bit pester);
        int          lat;
        logic [63:0] r;
        bit          trap_hit;
        lat      = o ? MULT_LAT : DIV_LAT;
        r        = o ? {mh, ml} : div_ref(a, b);
        trap_hit = TRAP && !o && (b == 32'd0);
        ua = a; ub = b; umh = mh; uml = ml;
        bus.start = 1'b1; bus.op = o; bus.abort = 1'b0;
        chk_cycle($sformatf("%s.c0", tag), 0, 0, 0, 0, 0);
        for (int c = 1; c <= lat + 2; c++) begin
            step();
            if (abort_cyc > 0 && c == abort_cyc + 1) begin
                chk_cycle($sformatf("%s.abort_c%0d", tag, c), 0, 0, 0, 0, 0);
                bus.start = 1'b0; bus.abort = 1'b0;
                return;
            end
            bus.start = pester ? 1'($urandom) : 1'b0;
            bus.op    = 1'($urandom);
            bus.abort = (c == abort_cyc);
            if (c == lat + 2) begin
                if (!trap_hit) {eh, el} = r;
                bus.abort = 1'($urandom);
                if (pester) bus.start = 1'b1;
            end
            chk_cycle($sformatf("%s.c%0d", tag, c), c <= lat + 1, c == lat + 2,
                      c == 1 && !o, c == 1 && o, c == lat + 2 && trap_hit);
        end
        step();
        chk_cycle($sformatf("%s.after", tag), 0, 0, 0, 0, 0);
        bus.start = 1'b0; bus.abort = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 1'b0; bus.abort = 1'b0;
        ua = 0; ub = 1; umh = 0; uml = 0; eh = 0; el = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 chk_cycle("reset", 0, 0, 0, 0, 0);
        bus.start = 1'b1;
        step();
        step();
        chk_cycle("reset_hold", 0, 0, 0, 0, 0);
        bus.start = 1'b0;
        #2 reset = 1'b1;
        step();
        chk_cycle("post_reset", 0, 0, 0, 0, 0);

        run_op("div_100_7", 0, 32'd100, 32'd7, 0, 0, 0, 0);
        run_op("div_m7_2", 0, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0);
        run_op("mult_1_2", 1, 32'd3, 32'd4, 32'd1, 32'd2, 0, 1);
        run_op("mult_5_6", 1, 32'd0, 32'd1, 32'd5, 32'd6, 0, 0);
        run_op("div_by0", 0, 32'd9, 32'd0, 0, 0, 0, 1);
        run_op("div_abort", 0, 32'd1000, 32'd3, 0, 0, 10, 1);
        run_op("mult_after_abort", 1, 0, 1, 32'hDEAD, 32'hBEEF, 0, 0);
        run_op("div_abort_issue", 0, 32'd77, 32'd5, 0, 0, 1, 0);

        // Reset in the middle of a WAIT phase.
        ua = 32'd50; ub = 32'd5;
        bus.start = 1'b1; bus.op = 1'b0;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        chk_cycle("pre_rst_mid", 1, 0, 0, 0, 0);
        #1 reset = 1'b0;
        #1 eh = 0; el = 0;
        chk_cycle("rst_mid", 0, 0, 0, 0, 0);
        bus.start = 1'b1;
        step();
        chk_cycle("rst_mid_hold", 0, 0, 0, 0, 0);
        bus.start = 1'b0;
        #2 reset = 1'b1;
        step();
        chk_cycle("rst_mid_rel", 0, 0, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            bit          o;
            int          lat, ab;
            logic [31:0] a, b;
            o   = 1'($urandom);
            lat = o ? MULT_LAT : DIV_LAT;
            a   = 32'($urandom_range(0, 2000)) - 32'd1000;
            b   = 32'($urandom_range(0, 100)) - 32'd50;
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat + 2)) : 0;
            run_op($sformatf("rnd%0d", i), o, a, b, $urandom, $urandom, ab, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
